// File: rtl/gpio_irq_ctrl.sv
// gpio_irq_ctrl: collects per-pin and aggregate GPIO interrupt handshakes into
// a pending register and serialises eligible pending sources into a single
// interrupt-ID stream. Each ID is presented over valid/ready. The consumer's
// acknowledge clears that source's pending bit.
// Selection is fixed priority (lowest index) or round-robin after the last grant.
// IDW must be wide enough to hold NSRC-1 (2**IDW >= NSRC).
module gpio_irq_ctrl #(
    parameter int NSRC = 9,
    parameter int IDW  = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NSRC-1:0] ir_valid,
    output logic [NSRC-1:0] ir_ready,
    input  logic [NSRC-1:0] mask,
    input  logic            rr_en,
    output logic            irq_valid,
    input  logic            irq_ready,
    output logic [IDW-1:0]  irq_id,
    output logic [NSRC-1:0] irq_pending
);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PRESENT = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [NSRC-1:0] r_pending;
    logic [NSRC-1:0] w_eligible;
    logic [NSRC-1:0] w_set;
    logic [NSRC-1:0] w_clr;
    logic            r_irq_valid;
    logic            w_irq_valid_nxt;
    logic [IDW-1:0]  r_irq_id;
    logic [IDW-1:0]  w_irq_id_nxt;
    logic [IDW-1:0]  r_last_grant;
    logic [IDW-1:0]  w_last_grant_nxt;
    logic [IDW-1:0]  w_winner;
    logic            w_ack;

    // Lowest-index set bit of elig, or 0 when elig is empty.
    function automatic logic [IDW-1:0] f_fixed_pick(input logic [NSRC-1:0] elig);
        logic [IDW-1:0] pick;
        pick = '0;
        for (int k = NSRC - 1; k >= 0; k--) begin
            if (elig[k]) begin
                pick = IDW'(k);
            end
        end
        return pick;
    endfunction

    // First set bit strictly above last, wrapping to the lowest set bit overall.
    function automatic logic [IDW-1:0] f_rr_pick(input logic [NSRC-1:0] elig,
                                                 input logic [IDW-1:0]  last);
        logic [IDW-1:0] pick_hi;
        logic           found_hi;
        int             lg;
        pick_hi  = '0;
        found_hi = 1'b0;
        lg       = int'(last);
        for (int k = NSRC - 1; k >= 0; k--) begin
            if (elig[k] && (k > lg)) begin
                pick_hi  = IDW'(k);
                found_hi = 1'b1;
            end
        end
        return found_hi ? pick_hi : f_fixed_pick(elig);
    endfunction

    // A source can only be accepted while it has nothing outstanding, so a set
    // and a clear never coincide on the same bit.
    assign ir_ready    = ~r_pending;
    assign w_set       = ir_valid & ~r_pending;
    assign w_clr       = w_ack ? (NSRC'(1) << r_irq_id) : '0;
    assign w_eligible  = r_pending & ~mask;
    assign irq_pending = r_pending;
    assign irq_valid   = r_irq_valid;
    assign irq_id      = r_irq_id;

    // Winner selection over the registered eligible set.
    always_comb begin
        w_winner = f_fixed_pick(w_eligible);
        if (rr_en) begin
            w_winner = f_rr_pick(w_eligible, r_last_grant);
        end
    end

    // Next-state logic: grant from IDLE, hold the ID in PRESENT until acknowledged.
    always_comb begin
        w_state_nxt      = r_state;
        w_irq_valid_nxt  = r_irq_valid;
        w_irq_id_nxt     = r_irq_id;
        w_last_grant_nxt = r_last_grant;
        w_ack            = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|w_eligible) begin
                    w_state_nxt     = S_PRESENT;
                    w_irq_valid_nxt = 1'b1;
                    w_irq_id_nxt    = w_winner;
                end
            end
            S_PRESENT: begin
                if (r_irq_valid && irq_ready) begin
                    w_ack            = 1'b1;
                    w_state_nxt      = S_IDLE;
                    w_irq_valid_nxt  = 1'b0;
                    w_last_grant_nxt = r_irq_id;
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_irq_valid_nxt = 1'b0;
            end
        endcase
    end

    // FSM and presented-ID registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_irq_valid  <= 1'b0;
            r_irq_id     <= '0;
            r_last_grant <= IDW'(NSRC - 1);
        end else begin
            r_state      <= w_state_nxt;
            r_irq_valid  <= w_irq_valid_nxt;
            r_irq_id     <= w_irq_id_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    // Pending register: set on accepted source handshake, cleared on acknowledge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending | w_set) & ~w_clr;
        end
    end

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Directed self-checking bench for gpio_irq_ctrl.
module tb_gpio_irq_ctrl;

    localparam int NSRC = 9;
    localparam int IDW  = 4;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [NSRC-1:0] ir_valid = '0;
    logic [NSRC-1:0] ir_ready;
    logic [NSRC-1:0] mask = '0;
    logic            rr_en = 1'b0;
    logic            irq_valid;
    logic            irq_ready = 1'b0;
    logic [IDW-1:0]  irq_id;
    logic [NSRC-1:0] irq_pending;

    int checks = 0;
    int errors = 0;

    gpio_irq_ctrl #(
        .NSRC(NSRC),
        .IDW (IDW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .mask       (mask),
        .rr_en      (rr_en),
        .irq_valid  (irq_valid),
        .irq_ready  (irq_ready),
        .irq_id     (irq_id),
        .irq_pending(irq_pending)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clock);
    endtask

    task automatic reset_dut();
        @(negedge clock);
        reset     = 1'b1;
        ir_valid  = '0;
        irq_ready = 1'b0;
        mask      = '0;
        rr_en     = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        step();
        step();
        reset = 1'b0;
        step();
        checks++; if (ir_ready !== 9'h1FF) begin errors++; $display("FAIL reset_ir_ready actual=%h required=1ff", ir_ready); end
        checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL reset_irq_valid actual=%b required=0", irq_valid); end
        checks++; if (irq_pending !== 9'h000) begin errors++; $display("FAIL reset_pending actual=%h required=000", irq_pending); end
        checks++; if (irq_id !== 4'd0) begin errors++; $display("FAIL reset_irq_id actual=%0d required=0", irq_id); end
    endtask

    task automatic test_single();
        reset_dut();
        ir_valid = 9'h008;
        step();
        ir_valid = '0;
        checks++; if (irq_pending !== 9'h008) begin errors++; $display("FAIL single_pending actual=%h required=008", irq_pending); end
        checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL single_valid_early actual=%b required=0", irq_valid); end
        checks++; if (ir_ready !== 9'h1F7) begin errors++; $display("FAIL single_ir_ready_busy actual=%h required=1f7", ir_ready); end
        step();
        checks++; if (irq_valid !== 1'b1) begin errors++; $display("FAIL single_valid actual=%b required=1", irq_valid); end
        checks++; if (irq_id !== 4'd3) begin errors++; $display("FAIL single_id actual=%0d required=3", irq_id); end
        irq_ready = 1'b1;
        step();
        irq_ready = 1'b0;
        checks++; if (irq_pending !== 9'h000) begin errors++; $display("FAIL single_pending_clr actual=%h required=000", irq_pending); end
        checks++; if (ir_ready !== 9'h1FF) begin errors++; $display("FAIL single_ir_ready_back actual=%h required=1ff", ir_ready); end
        checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop actual=%b required=0", irq_valid); end
    endtask

    task automatic test_fixed_order();
        int             exp_ids [3] = '{1, 5, 8};
        int             n;
        logic           exp_v;
        logic [IDW-1:0] exp_id;
        reset_dut();
        irq_ready = 1'b1;
        ir_valid  = 9'h122;
        step();
        ir_valid = '0;
        n = 0;
        for (int c = 0; c < 7; c++) begin
            step();
            exp_v = ((c % 2) == 0) && (c < 6);
            checks++; if (irq_valid !== exp_v) begin errors++; $display("FAIL fixed_valid_c%0d actual=%b required=%b", c, irq_valid, exp_v); end
            if (exp_v) begin
                exp_id = IDW'(exp_ids[n]);
                checks++; if (irq_id !== exp_id) begin errors++; $display("FAIL fixed_id_c%0d actual=%0d required=%0d", c, irq_id, exp_id); end
                n++;
            end
        end
        checks++; if (irq_pending !== 9'h000) begin errors++; $display("FAIL fixed_drained actual=%h required=000", irq_pending); end
        irq_ready = 1'b0;
    endtask

    task automatic test_round_robin();
        logic           exp_v;
        logic [IDW-1:0] exp_id;
        reset_dut();
        rr_en    = 1'b1;
        ir_valid = 9'h101;
        step();
        ir_valid = '0;
        step();
        checks++; if (irq_valid !== 1'b1 || irq_id !== 4'd0) begin errors++; $display("FAIL rr_first_after_reset actual=%b/%0d required=1/0", irq_valid, irq_id); end
        irq_ready = 1'b1;
        step();
        checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL rr_gap0 actual=%b required=0", irq_valid); end
        step();
        checks++; if (irq_valid !== 1'b1 || irq_id !== 4'd8) begin errors++; $display("FAIL rr_second actual=%b/%0d required=1/8", irq_valid, irq_id); end
        step();
        irq_ready = 1'b0;
        // Grant 5, then 2 and 7 wait: round-robin after 5 must choose 7 before 2.
        ir_valid = 9'h020;
        step();
        ir_valid = 9'h084;
        step();
        ir_valid = '0;
        checks++; if (irq_valid !== 1'b1 || irq_id !== 4'd5) begin errors++; $display("FAIL rr_grant5 actual=%b/%0d required=1/5", irq_valid, irq_id); end
        irq_ready = 1'b1;
        step();
        step();
        checks++; if (irq_valid !== 1'b1 || irq_id !== 4'd7) begin errors++; $display("FAIL rr_after5 actual=%b/%0d required=1/7", irq_valid, irq_id); end
        step();
        step();
        checks++; if (irq_valid !== 1'b1 || irq_id !== 4'd2) begin errors++; $display("FAIL rr_wrap2 actual=%b/%0d required=1/2", irq_valid, irq_id); end
        step();
        // Sources 0 and 2 held requesting; IDs must alternate 0,2,0,2.
        ir_valid = 9'h005;
        for (int c = 1; c <= 8; c++) begin
            step();
            exp_v  = ((c % 2) == 0);
            exp_id = ((c % 4) == 2) ? 4'd0 : 4'd2;
            checks++; if (irq_valid !== exp_v) begin errors++; $display("FAIL rr_alt_valid_c%0d actual=%b required=%b", c, irq_valid, exp_v); end
            if (exp_v) begin
                checks++; if (irq_id !== exp_id) begin errors++; $display("FAIL rr_alt_id_c%0d actual=%0d required=%0d", c, irq_id, exp_id); end
            end
        end
        ir_valid  = '0;
        irq_ready = 1'b0;
    endtask

    task automatic test_mask();
        int waited;
        reset_dut();
        mask     = 9'h010;
        ir_valid = 9'h010;
        step();
        ir_valid = '0;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++; if (irq_pending[4] !== 1'b1) begin errors++; $display("FAIL mask_pending_i%0d actual=%b required=1", i, irq_pending[4]); end
            checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL mask_valid_i%0d actual=%b required=0", i, irq_valid); end
            checks++; if (ir_ready[4] !== 1'b0) begin errors++; $display("FAIL mask_ir_ready_i%0d actual=%b required=0", i, ir_ready[4]); end
        end
        mask   = '0;
        waited = 0;
        while (irq_valid !== 1'b1 && waited < 2) begin
            step();
            waited++;
        end
        checks++; if (irq_valid !== 1'b1) begin errors++; $display("FAIL unmask_valid actual=%b required=1 within 2 cycles", irq_valid); end
        checks++; if (irq_id !== 4'd4) begin errors++; $display("FAIL unmask_id actual=%0d required=4", irq_id); end
    endtask

    task automatic test_hold();
        reset_dut();
        ir_valid = 9'h004;
        step();
        ir_valid = '0;
        step();
        checks++; if (irq_valid !== 1'b1 || irq_id !== 4'd2) begin errors++; $display("FAIL hold_start actual=%b/%0d required=1/2", irq_valid, irq_id); end
        ir_valid = 9'h001;
        mask     = 9'h004;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 0) ir_valid = '0;
            checks++; if (irq_valid !== 1'b1 || irq_id !== 4'd2) begin errors++; $display("FAIL hold_i%0d actual=%b/%0d required=1/2", i, irq_valid, irq_id); end
        end
        checks++; if (irq_pending !== 9'h005) begin errors++; $display("FAIL hold_pending actual=%h required=005", irq_pending); end
        irq_ready = 1'b1;
        step();
        checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL hold_gap actual=%b required=0", irq_valid); end
        step();
        checks++; if (irq_valid !== 1'b1 || irq_id !== 4'd0) begin errors++; $display("FAIL hold_next actual=%b/%0d required=1/0", irq_valid, irq_id); end
        irq_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        reset_dut();
        ir_valid = 9'h048;
        step();
        ir_valid = '0;
        step();
        checks++; if (irq_valid !== 1'b1 || irq_id !== 4'd3 || irq_pending !== 9'h048) begin errors++; $display("FAIL mid_pre actual=%b/%0d/%h required=1/3/048", irq_valid, irq_id, irq_pending); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid actual=%b required=0", irq_valid); end
        checks++; if (irq_pending !== 9'h000) begin errors++; $display("FAIL mid_async_pending actual=%h required=000", irq_pending); end
        checks++; if (ir_ready !== 9'h1FF) begin errors++; $display("FAIL mid_async_ready actual=%h required=1ff", ir_ready); end
        checks++; if (irq_id !== 4'd0) begin errors++; $display("FAIL mid_async_id actual=%0d required=0", irq_id); end
        step();
        reset = 1'b0;
        step();
        step();
        checks++; if (irq_valid !== 1'b0 || irq_pending !== 9'h000) begin errors++; $display("FAIL mid_lost actual=%b/%h required=0/000", irq_valid, irq_pending); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fixed_order();
        test_round_robin();
        test_mask();
        test_hold();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_irq_ctrl.md
Name: gpio_irq_ctrl

Overview:
- Interrupt collector/arbiter directly downstream of the GPIO port block.
- Consumes the per-pin interrupt handshakes plus the aggregate (all-condition) interrupt handshake.
- Latches each accepted request as pending and serialises pending requests into a single interrupt-ID stream over a valid/ready handshake.
- The CPU-side consumer acknowledges each ID, which clears the corresponding pending bit.

Parameters:
- NSRC, 9, number of interrupt sources; equals GPIO WIDTH+1, with index NSRC-1 being the aggregate source.
- IDW, 4, width of irq_id; must satisfy 2^IDW >= NSRC.

Ports:
- clock  input  1  single clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- ir_valid  input  NSRC  per-source interrupt request valid, from the GPIO block.
- ir_ready  output  NSRC  per-source accept; ir_ready[i] = ~pending[i].
- mask  input  NSRC  1 = source masked. A masked source still latches pending but is not presented.
- rr_en  input  1  0 = fixed priority (lowest index wins); 1 = round-robin.
- irq_valid  output  1  interrupt ID available.
- irq_ready  input  1  consumer accepts irq_id.
- irq_id  output  IDW  index of the presented source.
- irq_pending  output  NSRC  pending register, for status readback.

Behaviour:
- **Reset (async, immediate):**
  - pending = 0, so ir_ready = all ones.
  - irq_valid = 0, irq_id = 0, irq_pending = 0.
  - FSM = IDLE, last_grant = NSRC-1.
- **Capture:**
  - ir_valid[i] & ir_ready[i] at edge t sets pending[i] at t+1.
  - ir_ready[i] drops combinationally with pending[i], so at most one request per source is outstanding.
  - Upstream holds ir_valid until accepted.
- **Eligibility:** eligible = pending & ~mask, evaluated every cycle from registered state.
- **FSM, two states:**
  - **IDLE:**
    - If |eligible: select winner w, register irq_id <= w, irq_valid <= 1, go to PRESENT.
    - Else stay in IDLE.
  - **PRESENT:**
    - irq_id and irq_valid are held stable regardless of mask, rr_en or new requests.
    - On irq_valid & irq_ready: pending[irq_id] <= 0, last_grant <= irq_id, irq_valid <= 0, go to IDLE.
- **Latency:**
  - Source handshake at edge t gives irq_valid at t+2 when the controller is idle and the source is unmasked.
  - A mandatory one-cycle IDLE gap separates consecutive IDs, so max throughput is one ID per 2 cycles.
- **Selection:**
  - rr_en=0: lowest-index eligible source.
  - rr_en=1: first eligible source scanning last_grant+1, last_grant+2, ... with wrap from NSRC-1 to 0.
  - The first round-robin grant after reset starts at index 0.
  - Only the grant cycle matters: rr_en and mask changes take effect at the next IDLE evaluation.
- **Set/clear interaction:**
  - No same-cycle set/clear conflict exists for one source, because ir_ready[i] is 0 while pending[i] is set.
  - ir_ready[id] returns to 1 the cycle after acknowledge.
  - A new request on that source is accepted no earlier than the cycle after acknowledge.
- **Masking:**
  - Setting mask on a pending source leaves it pending indefinitely; the source is blocked upstream via ir_ready=0.
  - Clearing the mask makes it eligible at the next IDLE evaluation.
  - Masking the currently presented source does not retract irq_valid.
- **All masked:** FSM stays in IDLE and irq_valid stays 0 while pending accumulates.
- **irq_id width:** winner index is zero-extended to IDW. IDs >= NSRC are never produced.
- **Reset mid-operation:** an ID being presented is dropped without acknowledge and all pending requests are lost.

Test Plan:
1. Reset, no activity -> ir_ready=9'h1FF, irq_valid=0, irq_pending=0; assert reset while irq_valid=1 -> irq_valid=0 in the same cycle, before the next edge.
2. rr_en=0, mask=0; pulse ir_valid[3] one cycle -> irq_pending=9'h008 next cycle, irq_valid=1 with irq_id=3 two cycles after handshake; irq_ready=1 -> pending cleared, ir_ready[3]=1 next cycle.
3. rr_en=0; requests on sources 5, 1 and 8 in the same cycle, irq_ready held 1 -> IDs 1, 5, 8 in order, each separated by one idle cycle.
4. rr_en=1; sources 0 and 2 re-requested immediately after each acknowledge, irq_ready=1 -> IDs alternate 0, 2, 0, 2; after reset, a first simultaneous request on 0 and 8 -> ID 0 first.
5. mask=9'h010, request on 4 -> pending[4]=1, irq_valid stays 0, ir_ready[4]=0 for 20 cycles; clear mask -> irq_id=4 presented within 2 cycles.
6. irq_id=2 presented and irq_ready=0 for 10 cycles while source 0 requests and mask[2] is set -> irq_id stays 2 and irq_valid stays 1; after acknowledge, next ID=0.
